// File: rtl/clk_reset_seq.sv
// Staged reset sequencer: waits for a stable PLL lock, then releases the
// peripheral reset before the core reset. Option: CLK_RESET_SEQ_LOSS_CNT_EN.
module clk_reset_seq #(
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGE_GAP     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked_in,
  input  logic       sw_rst_req,
  output logic       rst_periph,
  output logic       rst_core,
  output logic       sys_ready
`ifdef CLK_RESET_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_count
`endif
);

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    STABLE     = 3'd1,
    REL_PERIPH = 3'd2,
    RUN        = 3'd3,
    SW_HOLD    = 3'd4
  } state_t;

  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST    = 16'(STAGE_GAP - 1);

  state_t      state;
  state_t      state_n;
  logic [15:0] cnt;
  logic [15:0] cnt_n;
  logic        sync1;
  logic        locked_s;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= locked_in;
      locked_s <= sync1;
    end
  end

  // State, counter and outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_LOCK;
      cnt        <= 16'd0;
      rst_periph <= 1'b1;
      rst_core   <= 1'b1;
      sys_ready  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      rst_periph <= !(state_n == REL_PERIPH || state_n == RUN);
      rst_core   <= (state_n != RUN);
      sys_ready  <= (state_n == RUN);
    end
  end

  // Next-state logic; lock loss always takes priority.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      WAIT_LOCK: begin
        cnt_n = 16'd0;
        if (locked_s) state_n = STABLE;
      end
      STABLE: begin
        if (!locked_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = 16'd0;
        end else if (cnt == STABLE_LAST) begin
          state_n = REL_PERIPH;
          cnt_n   = 16'd0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      REL_PERIPH: begin
        if (!locked_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = 16'd0;
        end else if (cnt == GAP_LAST) begin
          state_n = RUN;
          cnt_n   = 16'd0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      RUN: begin
        cnt_n = 16'd0;
        if (!locked_s) state_n = WAIT_LOCK;
        else if (sw_rst_req) state_n = SW_HOLD;
      end
      SW_HOLD: begin
        if (!locked_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = 16'd0;
        end else if (cnt == GAP_LAST) begin
          state_n = STABLE;
          cnt_n   = 16'd0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: begin
        state_n = WAIT_LOCK;
        cnt_n   = 16'd0;
      end
    endcase
  end

`ifdef CLK_RESET_SEQ_LOSS_CNT_EN
  logic loss;

  assign loss = !locked_s &&
    (state == REL_PERIPH || state == RUN || state == SW_HOLD);

  // Saturating count of lock losses after the peripherals were released.
  always_ff @(posedge clk) begin
    if (reset)
      lock_loss_count <= 8'd0;
    else if (loss && lock_loss_count != 8'hFF)
      lock_loss_count <= lock_loss_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_clk_reset_seq.sv
// Directed bench for clk_reset_seq with STABLE_CYCLES=8, STAGE_GAP=4.
// Loss counter checks are active when CLK_RESET_SEQ_LOSS_CNT_EN is defined.
module tb_clk_reset_seq;

  logic clk = 1'b0;
  logic reset;
  logic locked_in;
  logic sw_rst_req;
  logic rst_periph;
  logic rst_core;
  logic sys_ready;
`ifdef CLK_RESET_SEQ_LOSS_CNT_EN
  logic [7:0] lock_loss_count;
`endif

  int total  = 0;
  int passed = 0;
  int e      = 0;

  clk_reset_seq #(
    .STABLE_CYCLES(8),
    .STAGE_GAP(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .locked_in(locked_in),
    .sw_rst_req(sw_rst_req),
    .rst_periph(rst_periph),
    .rst_core(rst_core),
    .sys_ready(sys_ready)
`ifdef CLK_RESET_SEQ_LOSS_CNT_EN
    ,
    .lock_loss_count(lock_loss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic tick_to(input int n);
    while (e < n) tick();
  endtask

  task automatic chk_cnt(input string tag, input int exp);
`ifdef CLK_RESET_SEQ_LOSS_CNT_EN
    check(tag, 32'(lock_loss_count), 32'(exp));
`endif
  endtask

  // Two reset cycles, then locked_in high from cycle 0.
  task automatic do_reset();
    reset      = 1'b1;
    locked_in  = 1'b0;
    sw_rst_req = 1'b0;
    tick();
    tick();
    reset     = 1'b0;
    locked_in = 1'b1;
    e         = 0;
  endtask

  task automatic wait_periph(input logic v, input string tag);
    int n;
    n = 0;
    while (rst_periph !== v && n < 64) begin
      tick();
      n++;
    end
    check(tag, 32'(rst_periph), 32'(v));
  endtask

  initial begin
    // Power-on sequence then lock loss in RUN
    do_reset();
    check("rst_periph_reset", 32'(rst_periph), 32'd1);
    check("rst_core_reset", 32'(rst_core), 32'd1);
    check("ready_reset", 32'(sys_ready), 32'd0);
    chk_cnt("cnt_reset", 0);
    tick_to(10);
    check("po_periph_e10", 32'(rst_periph), 32'd1);
    tick_to(11);
    check("po_periph_e11", 32'(rst_periph), 32'd0);
    check("po_core_e11", 32'(rst_core), 32'd1);
    tick_to(14);
    check("po_core_e14", 32'(rst_core), 32'd1);
    check("po_ready_e14", 32'(sys_ready), 32'd0);
    tick_to(15);
    check("po_core_e15", 32'(rst_core), 32'd0);
    check("po_ready_e15", 32'(sys_ready), 32'd1);
    tick_to(40);
    locked_in = 1'b0;
    tick_to(42);
    check("loss_core_e42", 32'(rst_core), 32'd0);
    check("loss_ready_e42", 32'(sys_ready), 32'd1);
    tick_to(43);
    check("loss_periph_e43", 32'(rst_periph), 32'd1);
    check("loss_core_e43", 32'(rst_core), 32'd1);
    check("loss_ready_e43", 32'(sys_ready), 32'd0);
    chk_cnt("loss_cnt", 1);

    // Software re-sequence from RUN
    do_reset();
    tick_to(20);
    sw_rst_req = 1'b1;
    tick_to(21);
    sw_rst_req = 1'b0;
    check("sw_periph_e21", 32'(rst_periph), 32'd1);
    check("sw_core_e21", 32'(rst_core), 32'd1);
    check("sw_ready_e21", 32'(sys_ready), 32'd0);
    tick_to(32);
    check("sw_periph_e32", 32'(rst_periph), 32'd1);
    tick_to(33);
    check("sw_periph_e33", 32'(rst_periph), 32'd0);
    check("sw_core_e33", 32'(rst_core), 32'd1);
    tick_to(36);
    check("sw_core_e36", 32'(rst_core), 32'd1);
    tick_to(37);
    check("sw_core_e37", 32'(rst_core), 32'd0);
    check("sw_ready_e37", 32'(sys_ready), 32'd1);
    chk_cnt("sw_cnt", 0);

    // One-cycle lock glitch during STABLE restarts the count
    do_reset();
    tick_to(5);
    locked_in = 1'b0;
    tick_to(6);
    locked_in = 1'b1;
    tick_to(11);
    check("gl_periph_e11", 32'(rst_periph), 32'd1);
    tick_to(16);
    check("gl_periph_e16", 32'(rst_periph), 32'd1);
    tick_to(17);
    check("gl_periph_e17", 32'(rst_periph), 32'd0);
    chk_cnt("gl_cnt", 0);

    // Lock loss and sw request in the same cycle: loss wins
    do_reset();
    tick_to(40);
    locked_in = 1'b0;
    tick_to(41);
    locked_in = 1'b1;
    tick_to(42);
    sw_rst_req = 1'b1;
    tick_to(43);
    sw_rst_req = 1'b0;
    check("both_periph_e43", 32'(rst_periph), 32'd1);
    check("both_ready_e43", 32'(sys_ready), 32'd0);
    tick_to(51);
    check("both_periph_e51", 32'(rst_periph), 32'd1);
    tick_to(52);
    check("both_periph_e52", 32'(rst_periph), 32'd0);
    chk_cnt("both_cnt", 1);

    // Reset asserted during REL_PERIPH
    do_reset();
    tick_to(12);
    reset = 1'b1;
    tick_to(13);
    check("mid_periph_e13", 32'(rst_periph), 32'd1);
    check("mid_core_e13", 32'(rst_core), 32'd1);
    check("mid_ready_e13", 32'(sys_ready), 32'd0);
    chk_cnt("mid_cnt", 0);
    reset = 1'b0;
    tick_to(23);
    check("mid_periph_e23", 32'(rst_periph), 32'd1);
    tick_to(24);
    check("mid_periph_e24", 32'(rst_periph), 32'd0);

`ifdef CLK_RESET_SEQ_LOSS_CNT_EN
    // 300 loss events saturate the counter
    do_reset();
    for (int i = 0; i < 300; i++) begin
      wait_periph(1'b0, "sat_release");
      locked_in = 1'b0;
      wait_periph(1'b1, "sat_loss");
      locked_in = 1'b1;
    end
    chk_cnt("sat_cnt", 255);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clk_reset_seq.md
CLK_RESET_SEQ -- requirements
Module: clk_reset_seq

Interface
REQ-001 SHALL provide parameter STABLE_CYCLES, default 1024: clk cycles locked must stay high before any reset release (legal range 2..65535).
REQ-002 SHALL provide parameter STAGE_GAP, default 16: clk cycles between rst_periph release and rst_core release, and software-reset hold length (legal range 2..255).
REQ-003 SHALL have port clk  input  1  system clock, the single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port locked_in  input  1  PLL lock indication, asynchronous to clk.
REQ-006 SHALL have port sw_rst_req  input  1  single-cycle software re-sequence request.
REQ-007 SHALL have port rst_periph  output  1  active-high reset for peripherals and the RAM interface, released first.
REQ-008 SHALL have port rst_core  output  1  active-high reset for the CPU core, released last.
REQ-009 SHALL have port sys_ready  output  1  high only while both resets are deasserted.
REQ-010 SHALL have port lock_loss_count  output  8  saturating count of lock losses (present only under REQ-026).

Function
REQ-011 SHALL pass locked_in through a two-flop synchroniser to form locked_s, giving 2 cycles of latency.
REQ-012 SHALL implement the states WAIT_LOCK, STABLE, REL_PERIPH, RUN and SW_HOLD, using a 16-bit cycle counter cnt.
REQ-013 WAIT_LOCK SHALL hold both resets high with cnt=0, and SHALL go to STABLE when locked_s=1.
REQ-014 STABLE SHALL increment cnt, go to WAIT_LOCK when locked_s=0, and go to REL_PERIPH with cnt cleared when cnt=STABLE_CYCLES-1.
REQ-015 REL_PERIPH SHALL hold rst_periph=0 and rst_core=1, increment cnt, go to RUN when cnt=STAGE_GAP-1, and go to WAIT_LOCK when locked_s=0.
REQ-016 RUN SHALL hold both resets low and sys_ready=1, go to WAIT_LOCK when locked_s=0, and go to SW_HOLD with cnt cleared when sw_rst_req=1.
REQ-017 SW_HOLD SHALL hold both resets high, count to STAGE_GAP-1, then go to STABLE with cnt cleared; if locked_s=0, it SHALL go to WAIT_LOCK instead.
REQ-018 When locked_s=0 and sw_rst_req=1 arrive in the same cycle, lock loss SHALL win and the request SHALL be dropped.
REQ-019 sw_rst_req in any state other than RUN SHALL be ignored.
REQ-020 rst_periph, rst_core and sys_ready SHALL be registered and decoded from the next state, so they change on the same edge as the state.
REQ-021 With locked_in held high from cycle 0, rst_periph SHALL fall at edge STABLE_CYCLES+3 and rst_core and sys_ready SHALL rise/fall together at edge STABLE_CYCLES+STAGE_GAP+3.
REQ-022 A locked_in drop seen in REL_PERIPH or RUN SHALL reassert both resets exactly 3 edges after locked_in is first sampled low.
REQ-023 Any locked_s glitch during STABLE SHALL restart the full STABLE_CYCLES count; no partial credit is kept.

Reset
REQ-024 On reset=1 at a clk edge, the block SHALL set state=WAIT_LOCK, cnt=0, both synchroniser flops=0, rst_periph=1, rst_core=1, sys_ready=0 and lock_loss_count=0.
REQ-025 Reset asserted mid-sequence, in any state, SHALL abort the sequence immediately, with the REQ-024 values visible after that edge.

Configuration
REQ-026 With macro CLK_RESET_SEQ_LOSS_CNT_EN defined, the block SHALL include lock_loss_count, incremented by 1 (saturating at 255) on each transition from REL_PERIPH, RUN or SW_HOLD into WAIT_LOCK caused by locked_s=0.
REQ-027 Without CLK_RESET_SEQ_LOSS_CNT_EN, the port and its counter SHALL be absent, with all other behaviour identical.

Verification (STABLE_CYCLES=8, STAGE_GAP=4)
REQ-028 Power-on: reset for 2 cycles, then locked_in=1 at cycle 0 -> rst_periph falls at edge 11, rst_core falls and sys_ready rises at edge 15.
REQ-029 Glitch in STABLE: locked_in low for 1 cycle at cycle 5 -> rst_periph stays high until 8+3 edges after locked_in is re-sampled high.
REQ-030 Lock loss in RUN: locked_in falls at cycle 40 -> both resets high and sys_ready=0 at edge 43; lock_loss_count=1 when the macro is defined.
REQ-031 sw_rst_req pulse in RUN -> resets high for 4 cycles, then 8 cycles in STABLE, then staged release again; lock_loss_count is unchanged.
REQ-032 Same-cycle locked_s=0 and sw_rst_req=1 -> next state is WAIT_LOCK, not SW_HOLD; 300 forced loss events -> lock_loss_count saturates at 255.
REQ-033 reset asserted during REL_PERIPH -> next edge shows rst_periph=1, rst_core=1, state WAIT_LOCK, and the counter cleared.
